// File: rtl/pharmacy_req_frontend.sv
// Request front-end for the check-in heap: buffers kiosk requests, stamps arrivals with a
// prescaled clock, tracks heap occupancy and sequences commands and the list handshake.
module pharmacy_req_frontend #(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 16,
  parameter int CAPACITY   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [4:0] req_id,
  output logic [4:0] mem_studentID,
  output logic [1:0] mem_mode,
  output logic [7:0] mem_checkInTime,
  input  logic       mem_ready,
  input  logic       mem_listBusy,
  output logic [3:0] occupancy,
  output logic [7:0] cur_time,
  output logic       list_active,
  output logic       reject
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]    CAP       = 4'(CAPACITY);

  localparam logic [1:0] OP_LIST    = 2'b00;
  localparam logic [1:0] OP_NOP     = 2'b01;
  localparam logic [1:0] OP_CHECKIN = 2'b10;
  localparam logic [1:0] OP_DELETE  = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] id;
    logic [7:0] ts;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_LIST_ISSUE,
    S_LIST_WAIT
  } state_t;

  state_t        state_q;
  logic [1:0]    cmd_op_q;
  logic [4:0]    sid_q;
  logic [7:0]    ts_q;
  logic [3:0]    occ_q;
  logic          reject_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    time_q, time_d;

  entry_t        fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic   enq_fire, enq_bad, push, pop, issue_drop;
  entry_t head, new_entry;

  // listBusy is informational only; termination of a list relies on ready alone.
  logic unused_list_busy;
  assign unused_list_busy = mem_listBusy;

  assign req_ready = (count_q != FIFO_FULL);
  assign enq_fire  = req_valid && req_ready;
  assign enq_bad   = (req_op == OP_NOP) || ((req_op == OP_CHECKIN) && (req_id == 5'd0));
  assign push      = enq_fire && !enq_bad;
  assign head      = fifo_q[rd_ptr_q];
  assign pop       = ((state_q == S_IDLE) || (state_q == S_CMD)) && (count_q != '0);
  assign issue_drop = pop && (head.op == OP_CHECKIN) && (occ_q == CAP);

  assign new_entry = '{op: req_op, id: req_id, ts: time_q};

  always_comb begin
    presc_d = presc_q + PW'(1);
    time_d  = time_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      if (time_q != 8'hFF) time_d = time_q + 8'd1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (!push && pop) count_d = count_q - (AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      time_q   <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      time_q   <= time_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      reject_q <= (enq_fire && enq_bad) || issue_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cmd_op_q <= OP_NOP;
      sid_q    <= 5'd0;
      ts_q     <= 8'd0;
      occ_q    <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_CMD: begin
          if (pop) begin
            cmd_op_q <= head.op;
            sid_q    <= head.id;
            ts_q     <= head.ts;
            case (head.op)
              OP_CHECKIN: begin
                if (occ_q == CAP) begin
                  state_q <= S_IDLE;
                end else begin
                  state_q <= S_CMD;
                  occ_q   <= occ_q + 4'd1;
                end
              end
              // A delete on an empty heap is still forwarded; the memory tolerates it.
              OP_DELETE: begin
                state_q <= S_CMD;
                if (occ_q != 4'd0) occ_q <= occ_q - 4'd1;
              end
              default: state_q <= S_LIST_ISSUE;
            endcase
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LIST_ISSUE: state_q <= S_LIST_WAIT;
        S_LIST_WAIT:  if (mem_ready) state_q <= S_IDLE;
        default:      state_q <= S_IDLE;
      endcase
    end
  end

  // Mode falls to NOP combinationally with ready so the memory never restarts a list.
  always_comb begin
    mem_mode = OP_NOP;
    case (state_q)
      S_CMD:        mem_mode = cmd_op_q;
      S_LIST_ISSUE: mem_mode = OP_LIST;
      S_LIST_WAIT:  mem_mode = mem_ready ? OP_NOP : OP_LIST;
      default:      mem_mode = OP_NOP;
    endcase
  end

  assign mem_studentID   = sid_q;
  assign mem_checkInTime = ts_q;
  assign occupancy       = occ_q;
  assign cur_time        = time_q;
  assign list_active     = (state_q == S_LIST_ISSUE) || (state_q == S_LIST_WAIT);
  assign reject          = reject_q;

endmodule

// File: tb/tb_pharmacy_req_frontend.sv
// Scoreboarded bench for pharmacy_req_frontend with a small behavioural heap-memory responder.
module tb_pharmacy_req_frontend;

  localparam int TD  = 2;
  localparam int CAP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [4:0] req_id;
  logic [4:0] mem_studentID;
  logic [1:0] mem_mode;
  logic [7:0] mem_checkInTime;
  logic       mem_ready = 1'b1;
  logic       mem_listBusy = 1'b0;
  logic [3:0] occupancy;
  logic [7:0] cur_time;
  logic       list_active;
  logic       reject;

  always #5 clk = ~clk;

  pharmacy_req_frontend #(.FIFO_DEPTH(4), .TICK_DIV(TD), .CAPACITY(CAP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
    .mem_studentID(mem_studentID), .mem_mode(mem_mode), .mem_checkInTime(mem_checkInTime),
    .mem_ready(mem_ready), .mem_listBusy(mem_listBusy),
    .occupancy(occupancy), .cur_time(cur_time), .list_active(list_active), .reject(reject)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic [4:0] id;
    logic [7:0] ts;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_occ = 0;
  int edges = 0;
  int rej_seen = 0, la_seen = 0, m00 = 0, m10 = 0, m11 = 0;

  // Heap memory stand-in: no reset, holds ready low for (entries+1) edges while listing.
  logic [3:0] m_cnt = 4'd0;
  logic       m_busy = 1'b0;
  int         m_left = 0;
  int         list_starts = 0;

  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  always @(posedge clk) begin
    if (m_busy) begin
      if (m_left == 0) begin
        m_busy       <= 1'b0;
        mem_ready    <= 1'b1;
        mem_listBusy <= 1'b0;
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      case (mem_mode)
        2'b10: m_cnt <= m_cnt + 4'd1;
        2'b11: if (m_cnt != 4'd0) m_cnt <= m_cnt - 4'd1;
        2'b00: begin
          list_starts <= list_starts + 1;
          if (m_cnt != 4'd0) begin
            m_busy       <= 1'b1;
            mem_ready    <= 1'b0;
            mem_listBusy <= 1'b1;
            m_left       <= int'(m_cnt);
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (reject)          rej_seen++;
      if (list_active)     la_seen++;
      if (mem_mode == 2'b00) m00++;
      if (mem_mode == 2'b10 || mem_mode == 2'b11) begin
        if (mem_mode == 2'b10) m10++; else m11++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: mode=%b id=%0d ts=%0d, required no command", mem_mode, mem_studentID, mem_checkInTime);
        end else begin
          e = sb.pop_front();
          if (mem_mode !== e.mode ||
              (e.mode == 2'b10 && (mem_studentID !== e.id || mem_checkInTime !== e.ts))) begin
            n_bad++;
            $display("FAIL sb_cmd: mode=%b id=%0d ts=%0d, required mode=%b id=%0d ts=%0d",
                     mem_mode, mem_studentID, mem_checkInTime, e.mode, e.id, e.ts);
          end
        end
      end
    end
  end

  function automatic int exp_time(input int e);
    return (e / TD > 255) ? 255 : e / TD;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [1:0] op, input logic [4:0] id);
    int guard;
    logic [7:0] stamp;
    guard = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_id    = id;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: req_ready=%b required 1", req_ready);
    end
    stamp = 8'(exp_time(edges));
    if (op == 2'b01 || (op == 2'b10 && id == 5'd0)) begin
      // dropped at enqueue
    end else if (op == 2'b10) begin
      if (exp_occ < CAP) begin
        exp_occ++;
        sb.push_back('{mode: 2'b10, id: id, ts: stamp});
      end
    end else if (op == 2'b11) begin
      if (exp_occ > 0) exp_occ--;
      sb.push_back('{mode: 2'b11, id: id, ts: stamp});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_mode", mem_mode, 1);
    check("rst_list_active", list_active, 0);
    check("rst_reject", reject, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_cur_time", cur_time, 0);
    check("rst_studentID", mem_studentID, 0);
    check("rst_checkInTime", mem_checkInTime, 0);
  endtask

  int b00, b10, b11, bla, bls, brej;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b01; req_id = 5'd0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    b10 = m10;
    send(2'b10, 5'd5); send(2'b10, 5'd3); send(2'b10, 5'd7);
    repeat (6) @(negedge clk);
    check("t1_occupancy", occupancy, 3);
    check("t1_checkins", m10 - b10, 3);
    check("t1_cur_time", cur_time, exp_time(edges));

    b00 = m00; bla = la_seen; bls = list_starts;
    send(2'b00, 5'd0);
    repeat (12) @(negedge clk);
    check("list3_starts", list_starts - bls, 1);
    check("list3_active_cycles", la_seen - bla, 6);
    check("list3_mode00_cycles", m00 - b00, 5);
    check("list3_active_after", list_active, 0);
    check("list3_mode_after", mem_mode, 1);

    send(2'b11, 5'd0); send(2'b11, 5'd0); send(2'b11, 5'd0);
    repeat (5) @(negedge clk);
    check("del3_occupancy", occupancy, 0);

    b00 = m00; bla = la_seen; bls = list_starts;
    send(2'b00, 5'd0);
    repeat (6) @(negedge clk);
    check("list0_starts", list_starts - bls, 1);
    check("list0_active_cycles", la_seen - bla, 2);
    check("list0_mode00_cycles", m00 - b00, 1);

    b10 = m10; brej = rej_seen;
    for (int i = 1; i <= 11; i++) send(2'b10, 5'(i));
    repeat (8) @(negedge clk);
    check("cap_occupancy", occupancy, 10);
    check("cap_checkins", m10 - b10, 10);
    check("cap_rejects", rej_seen - brej, 1);
    b11 = m11;
    send(2'b11, 5'd0);
    repeat (4) @(negedge clk);
    check("cap_del_occupancy", occupancy, 9);
    check("cap_del_cycles", m11 - b11, 1);

    b10 = m10; b11 = m11; brej = rej_seen;
    send(2'b01, 5'd9); send(2'b10, 5'd0);
    repeat (5) @(negedge clk);
    check("illegal_rejects", rej_seen - brej, 2);
    check("illegal_issued", (m10 - b10) + (m11 - b11), 0);
    check("illegal_occupancy", occupancy, 9);

    send(2'b00, 5'd0);
    for (int i = 0; i < 4; i++) send(2'b11, 5'd0);
    check("fill_req_ready", req_ready, 0);
    check("fill_list_active", list_active, 1);
    repeat (25) @(negedge clk);
    check("fill_occupancy", occupancy, 5);
    check("fill_list_done", list_active, 0);

    repeat (600) @(negedge clk);
    check("timer_saturated", cur_time, 255);
    check("timer_model", cur_time, exp_time(edges));

    send(2'b00, 5'd0);
    repeat (2) @(negedge clk);
    check("midlist_active", list_active, 1);
    check("midlist_mode", mem_mode, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    exp_occ = 0;
    repeat (15) @(negedge clk);
    bls = list_starts;
    send(2'b00, 5'd0);
    repeat (15) @(negedge clk);
    check("relist_starts", list_starts - bls, 1);
    check("relist_active_after", list_active, 0);
    check("relist_mode_after", mem_mode, 1);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
